// File: rtl/sram_march_bist_pkg.sv
// Shared widths, March C- state encoding and per-element helpers for the SRAM BIST.
// The optional first-failure diagnostics are controlled by the BIST_DIAG_EN macro in the top.
package sram_march_bist_pkg;

  localparam int SRAM_ADDR_WIDTH = 8;
  localparam int SRAM_WORD_WIDTH = 4;
  localparam int SRAM_DEPTH      = 1 << SRAM_ADDR_WIDTH;

  localparam logic [SRAM_WORD_WIDTH-1:0] BIST_D0 = '0;
  localparam logic [SRAM_WORD_WIDTH-1:0] BIST_D1 = '1;

  typedef enum logic [3:0] {
    BIST_IDLE  = 4'd0,
    BIST_M0    = 4'd1,
    BIST_M1    = 4'd2,
    BIST_M2    = 4'd3,
    BIST_M3    = 4'd4,
    BIST_M4    = 4'd5,
    BIST_M5    = 4'd6,
    BIST_FLUSH = 4'd7,
    BIST_DONE  = 4'd8
  } bist_state_e;

  function automatic logic elem_ascending(input bist_state_e s);
    return !(s == BIST_M3 || s == BIST_M4);
  endfunction

  // Elements that visit each address twice: read then write.
  function automatic logic elem_is_rw(input bist_state_e s);
    return (s == BIST_M1 || s == BIST_M2 || s == BIST_M3 || s == BIST_M4);
  endfunction

  function automatic logic elem_rd_ones(input bist_state_e s);
    return (s == BIST_M2 || s == BIST_M4);
  endfunction

  function automatic logic elem_wr_ones(input bist_state_e s);
    return (s == BIST_M1 || s == BIST_M3);
  endfunction

  function automatic bist_state_e elem_next(input bist_state_e s);
    case (s)
      BIST_M0: return BIST_M1;
      BIST_M1: return BIST_M2;
      BIST_M2: return BIST_M3;
      BIST_M3: return BIST_M4;
      BIST_M4: return BIST_M5;
      BIST_M5: return BIST_FLUSH;
      default: return BIST_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/bist_addr_gen.sv
// Loadable up/down address counter for the March BIST, with a terminal-count flag
// that reflects the currently selected direction.
module bist_addr_gen #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_i,
  input  logic [ADDR_WIDTH-1:0] load_val_i,
  input  logic                  en_i,
  input  logic                  up_i,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic                  tc_o
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_LO = '0;
  localparam logic [ADDR_WIDTH-1:0] ADDR_HI = '1;

  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i) begin
      cnt_d = up_i ? cnt_q + ADDR_WIDTH'(1) : cnt_q - ADDR_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign addr_o = cnt_q;
  assign tc_o   = up_i ? (cnt_q == ADDR_HI) : (cnt_q == ADDR_LO);

endmodule

// File: rtl/sram_march_bist.sv
// March C- BIST controller for the single-port SRAM: drives address/data/we, compares
// registered read data one cycle later. Define BIST_DIAG_EN to build first-failure capture.
module sram_march_bist
  import sram_march_bist_pkg::*;
#(
  parameter int ADDR_WIDTH = SRAM_ADDR_WIDTH,
  parameter int WORD_WIDTH = SRAM_WORD_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [WORD_WIDTH-1:0] ram_data_in,
  output logic                  ram_we,
  input  logic [WORD_WIDTH-1:0] ram_data_out,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [7:0]            fail_count,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [WORD_WIDTH-1:0] fail_exp,
  output logic [WORD_WIDTH-1:0] fail_act
);

  localparam logic [WORD_WIDTH-1:0] D0      = '0;
  localparam logic [WORD_WIDTH-1:0] D1      = '1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_LO = '0;
  localparam logic [ADDR_WIDTH-1:0] ADDR_HI = '1;

  bist_state_e           state_q, state_d;
  logic                  wr_phase_q, wr_phase_d;
  logic                  addr_load, addr_en, addr_up, addr_tc;
  logic [ADDR_WIDTH-1:0] addr_load_val, addr;
  logic                  rd_cycle, start_acc, miscompare;
  logic [WORD_WIDTH-1:0] rd_exp;
  logic                  exp_vld_p1_q;
  logic [WORD_WIDTH-1:0] exp_word_p1_q;
  logic [7:0]            fail_count_q;

  bist_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_addr_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (addr_load),
    .load_val_i (addr_load_val),
    .en_i       (addr_en),
    .up_i       (addr_up),
    .addr_o     (addr),
    .tc_o       (addr_tc)
  );

  always_comb begin
    state_d       = state_q;
    wr_phase_d    = wr_phase_q;
    addr_load     = 1'b0;
    addr_load_val = ADDR_LO;
    addr_en       = 1'b0;
    addr_up       = elem_ascending(state_q);
    ram_we        = 1'b0;
    ram_data_in   = D0;
    rd_cycle      = 1'b0;
    rd_exp        = D0;
    start_acc     = 1'b0;
    unique case (state_q)
      BIST_IDLE, BIST_DONE: begin
        if (start) begin
          start_acc     = 1'b1;
          state_d       = BIST_M0;
          wr_phase_d    = 1'b0;
          addr_load     = 1'b1;
          addr_load_val = ADDR_LO;
        end
      end
      BIST_M0: begin
        ram_we  = 1'b1;
        addr_en = 1'b1;
        if (addr_tc) begin
          state_d       = elem_next(state_q);
          addr_load     = 1'b1;
          addr_load_val = ADDR_LO;
        end
      end
      BIST_M1, BIST_M2, BIST_M3, BIST_M4: begin
        if (!wr_phase_q) begin
          rd_cycle   = 1'b1;
          rd_exp     = elem_rd_ones(state_q) ? D1 : D0;
          wr_phase_d = 1'b1;
        end else begin
          ram_we      = 1'b1;
          ram_data_in = elem_wr_ones(state_q) ? D1 : D0;
          wr_phase_d  = 1'b0;
          addr_en     = 1'b1;
          // The next element's direction decides which end the counter reloads to.
          if (addr_tc) begin
            state_d       = elem_next(state_q);
            addr_load     = 1'b1;
            addr_load_val = elem_ascending(elem_next(state_q)) ? ADDR_LO : ADDR_HI;
          end
        end
      end
      BIST_M5: begin
        rd_cycle = 1'b1;
        rd_exp   = D0;
        addr_en  = 1'b1;
        if (addr_tc) begin
          state_d       = BIST_FLUSH;
          addr_load     = 1'b1;
          addr_load_val = ADDR_LO;
        end
      end
      BIST_FLUSH: begin
        state_d = BIST_DONE;
      end
      default: begin
        state_d    = BIST_IDLE;
        wr_phase_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= BIST_IDLE;
      wr_phase_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_phase_q <= wr_phase_d;
    end
  end

  // Stage p1: expected word registered alongside the read address; RAM data arrives here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_vld_p1_q <= 1'b0;
    end else begin
      exp_vld_p1_q <= rd_cycle;
    end
  end

  always_ff @(posedge clk) begin
    exp_word_p1_q <= rd_exp;
  end

  assign miscompare = exp_vld_p1_q && (ram_data_out != exp_word_p1_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_count_q <= 8'd0;
    end else if (start_acc) begin
      fail_count_q <= 8'd0;
    end else if (miscompare && fail_count_q != 8'hFF) begin
      fail_count_q <= fail_count_q + 8'd1;
    end
  end

`ifdef BIST_DIAG_EN
  logic [ADDR_WIDTH-1:0] exp_addr_p1_q;
  logic [ADDR_WIDTH-1:0] fail_addr_q;
  logic [WORD_WIDTH-1:0] fail_exp_q, fail_act_q;

  always_ff @(posedge clk) begin
    exp_addr_p1_q <= addr;
  end

  // A zero count marks the first miscompare since the last accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_addr_q <= '0;
      fail_exp_q  <= '0;
      fail_act_q  <= '0;
    end else if (start_acc) begin
      fail_addr_q <= '0;
      fail_exp_q  <= '0;
      fail_act_q  <= '0;
    end else if (miscompare && fail_count_q == 8'd0) begin
      fail_addr_q <= exp_addr_p1_q;
      fail_exp_q  <= exp_word_p1_q;
      fail_act_q  <= ram_data_out;
    end
  end

  assign fail_addr = fail_addr_q;
  assign fail_exp  = fail_exp_q;
  assign fail_act  = fail_act_q;
`else
  assign fail_addr = '0;
  assign fail_exp  = '0;
  assign fail_act  = '0;
`endif

  assign ram_addr   = addr;
  assign busy       = (state_q != BIST_IDLE) && (state_q != BIST_DONE);
  assign done       = (state_q == BIST_DONE);
  assign pass       = done && (fail_count_q == 8'd0);
  assign fail_count = fail_count_q;

endmodule
